// File: rtl/dual_port_ram_tdp.sv
// True dual-port synchronous RAM with byte enables, selectable same-port
// read-during-write, optional output register and write-collision tracking.
module dual_port_ram_tdp #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BYTE_WIDTH = 8,
   parameter int unsigned RD_MODE    = 0,
   parameter int unsigned OUT_REG    = 0,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             en_a,
   input  logic                             we_a,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_a,
   input  logic [ADDR_WIDTH-1:0]            addr_a,
   input  logic [DATA_WIDTH-1:0]            wdata_a,
   output logic [DATA_WIDTH-1:0]            rdata_a,
   output logic                             rvalid_a,
   input  logic                             en_b,
   input  logic                             we_b,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_b,
   input  logic [ADDR_WIDTH-1:0]            addr_b,
   input  logic [DATA_WIDTH-1:0]            wdata_b,
   output logic [DATA_WIDTH-1:0]            rdata_b,
   output logic                             rvalid_b,
   output logic                             coll,
   output logic [CNT_WIDTH-1:0]             coll_cnt
);

   localparam int unsigned NBYTES = DATA_WIDTH / BYTE_WIDTH;
   localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;

   // Byte lanes must tile the word exactly.
   if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $fatal(1, "DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  wr_a_c;
   logic                  wr_b_c;
   logic                  same_addr_c;
   logic                  coll_c;
   logic [DATA_WIDTH-1:0] old_a_c;
   logic [DATA_WIDTH-1:0] old_b_c;
   logic [DATA_WIDTH-1:0] rd_a_c;
   logic [DATA_WIDTH-1:0] rd_b_c;

   logic [DATA_WIDTH-1:0] rdata1_a;
   logic [DATA_WIDTH-1:0] rdata1_b;
   logic                  rvalid1_a;
   logic                  rvalid1_b;

   // New bytes where be is set, old bytes elsewhere.
   function automatic logic [DATA_WIDTH-1:0] merge_word(
      input logic [DATA_WIDTH-1:0] old_w,
      input logic [DATA_WIDTH-1:0] new_w,
      input logic [NBYTES-1:0]     be
   );
      logic [DATA_WIDTH-1:0] w;
      w = old_w;
      for (int unsigned i = 0; i < NBYTES; i++) begin
         if (be[i]) w[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      return w;
   endfunction

   // Access decode, collision detect and read-data selection.
   always_comb begin
      wr_a_c      = en_a & we_a;
      wr_b_c      = en_b & we_b;
      same_addr_c = (addr_a == addr_b);
      coll_c      = wr_a_c & wr_b_c & same_addr_c & (|(be_a & be_b));
      old_a_c     = mem[addr_a];
      old_b_c     = mem[addr_b];
      rd_a_c      = old_a_c;
      rd_b_c      = old_b_c;
      if (RD_MODE != 0 && wr_a_c) rd_a_c = merge_word(old_a_c, wdata_a, be_a);
      if (RD_MODE != 0 && wr_b_c) rd_b_c = merge_word(old_b_c, wdata_b, be_b);
   end

   // Array write; port A owns any lane both ports write at the same address.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
         if (wr_b_c && be_b[i] && !(wr_a_c && same_addr_c && be_a[i]))
            mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_b[i*BYTE_WIDTH +: BYTE_WIDTH];
         if (wr_a_c && be_a[i])
            mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   // First read stage; data holds while a port is idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata1_a  <= '0;
         rdata1_b  <= '0;
         rvalid1_a <= 1'b0;
         rvalid1_b <= 1'b0;
      end else begin
         rvalid1_a <= en_a;
         rvalid1_b <= en_b;
         if (en_a) rdata1_a <= rd_a_c;
         if (en_b) rdata1_b <= rd_b_c;
      end
   end

   // Collision pulse and saturating counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coll     <= 1'b0;
         coll_cnt <= '0;
      end else begin
         coll <= coll_c;
         if (coll_c && (coll_cnt != {CNT_WIDTH{1'b1}}))
            coll_cnt <= coll_cnt + CNT_WIDTH'(1);
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] rdata2_a;
      logic [DATA_WIDTH-1:0] rdata2_b;
      logic                  rvalid2_a;
      logic                  rvalid2_b;

      // Second stage: plain copy of the first, valid travels with data.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rdata2_a  <= '0;
            rdata2_b  <= '0;
            rvalid2_a <= 1'b0;
            rvalid2_b <= 1'b0;
         end else begin
            rdata2_a  <= rdata1_a;
            rdata2_b  <= rdata1_b;
            rvalid2_a <= rvalid1_a;
            rvalid2_b <= rvalid1_b;
         end
      end

      assign rdata_a  = rdata2_a;
      assign rdata_b  = rdata2_b;
      assign rvalid_a = rvalid2_a;
      assign rvalid_b = rvalid2_b;
   end else begin : g_no_out_reg
      assign rdata_a  = rdata1_a;
      assign rdata_b  = rdata1_b;
      assign rvalid_a = rvalid1_a;
      assign rvalid_b = rvalid1_b;
   end

endmodule

// File: tb/tb_dual_port_ram_tdp.sv
// Directed bench: three RAM variants (defaults; WRITE_FIRST with 2-bit
// counter; output register) driven by the same stimulus.
module tb_dual_port_ram_tdp;

   logic        clk;
   logic        rst_n;
   logic        en_a, we_a, en_b, we_b;
   logic [3:0]  be_a, be_b;
   logic [7:0]  addr_a, addr_b;
   logic [31:0] wdata_a, wdata_b;

   logic [31:0] rd_a [3];
   logic [31:0] rd_b [3];
   logic        rv_a [3];
   logic        rv_b [3];
   logic        cl   [3];
   logic [7:0]  cnt0;
   logic [1:0]  cnt1;
   logic [7:0]  cnt2;

   int n_cmp;
   int n_err;
   int pulses;

   dual_port_ram_tdp u0 (
      .clk(clk), .rst_n(rst_n),
      .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .rdata_a(rd_a[0]), .rvalid_a(rv_a[0]),
      .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .rdata_b(rd_b[0]), .rvalid_b(rv_b[0]),
      .coll(cl[0]), .coll_cnt(cnt0)
   );

   dual_port_ram_tdp #(.RD_MODE(1), .CNT_WIDTH(2)) u1 (
      .clk(clk), .rst_n(rst_n),
      .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .rdata_a(rd_a[1]), .rvalid_a(rv_a[1]),
      .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .rdata_b(rd_b[1]), .rvalid_b(rv_b[1]),
      .coll(cl[1]), .coll_cnt(cnt1)
   );

   dual_port_ram_tdp #(.OUT_REG(1)) u2 (
      .clk(clk), .rst_n(rst_n),
      .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .rdata_a(rd_a[2]), .rvalid_a(rv_a[2]),
      .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .rdata_b(rd_b[2]), .rvalid_b(rv_b[2]),
      .coll(cl[2]), .coll_cnt(cnt2)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic en, input logic we, input logic [3:0] be,
                        input logic [7:0] addr, input logic [31:0] d);
      en_a = en; we_a = we; be_a = be; addr_a = addr; wdata_a = d;
   endtask

   task automatic set_b(input logic en, input logic we, input logic [3:0] be,
                        input logic [7:0] addr, input logic [31:0] d);
      en_b = en; we_b = we; be_b = be; addr_b = addr; wdata_b = d;
   endtask

   task automatic idle();
      set_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
      set_b(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
   endtask

   // Directed sequence.
   initial begin
      n_cmp  = 0;
      n_err  = 0;
      pulses = 0;
      rst_n  = 1'b0;
      idle();
      repeat (3) cyc();

      check("rst_rdata_a",  rd_a[0], 32'h0);
      check("rst_rvalid_b", 32'(rv_b[0]), 32'h0);
      check("rst_coll",     32'(cl[0]), 32'h0);
      check("rst_cnt",      32'(cnt0), 32'h0);
      check("rst_rdata_b2", rd_b[2], 32'h0);
      rst_n = 1'b1;
      cyc();

      // Byte-enable merge on port A, read back through port B.
      set_a(1'b1, 1'b1, 4'hF, 8'h10, 32'hAABBCCDD); cyc();
      set_a(1'b1, 1'b1, 4'h5, 8'h10, 32'h11223344); cyc();
      set_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
      set_b(1'b1, 1'b0, 4'h0, 8'h10, 32'h0); cyc();
      check("be_rdata_b",   rd_b[0], 32'hAA22CC44);
      check("be_rvalid_b",  32'(rv_b[0]), 32'h1);
      check("be_rvalid_b2_early", 32'(rv_b[2]), 32'h0);
      idle(); cyc();
      check("be_rvalid_b_drop", 32'(rv_b[0]), 32'h0);
      check("be_rdata_b_hold",  rd_b[0], 32'hAA22CC44);
      check("be_rvalid_b2",     32'(rv_b[2]), 32'h1);
      check("be_rdata_b2",      rd_b[2], 32'hAA22CC44);
      cyc();
      check("be_rvalid_b2_drop", 32'(rv_b[2]), 32'h0);

      // we with no byte enables is a pure read.
      set_a(1'b1, 1'b1, 4'h0, 8'h10, 32'h0); cyc();
      check("be0_rdata_a",  rd_a[0], 32'hAA22CC44);
      check("be0_rdata_a1", rd_a[1], 32'hAA22CC44);
      set_a(1'b1, 1'b0, 4'h0, 8'h10, 32'h0); cyc();
      check("be0_kept", rd_a[0], 32'hAA22CC44);

      // Boundary addresses written from opposite ports.
      set_a(1'b1, 1'b1, 4'hF, 8'h00, 32'h0BAD0000);
      set_b(1'b1, 1'b1, 4'hF, 8'hFF, 32'hCAFEF00D); cyc();
      check("edge_no_coll", 32'(cl[0]), 32'h0);
      set_a(1'b1, 1'b0, 4'h0, 8'hFF, 32'h0);
      set_b(1'b1, 1'b0, 4'h0, 8'h00, 32'h0); cyc();
      check("edge_top", rd_a[0], 32'hCAFEF00D);
      check("edge_bot", rd_b[0], 32'h0BAD0000);

      // Read-during-write, same port and cross port.
      idle();
      set_a(1'b1, 1'b1, 4'hF, 8'h20, 32'h0); cyc();
      set_a(1'b1, 1'b1, 4'hF, 8'h20, 32'h12345678);
      set_b(1'b1, 1'b0, 4'h0, 8'h20, 32'h0); cyc();
      check("rdw_read_first",  rd_a[0], 32'h00000000);
      check("rdw_write_first", rd_a[1], 32'h12345678);
      check("rdw_cross_m0",    rd_b[0], 32'h00000000);
      check("rdw_cross_m1",    rd_b[1], 32'h00000000);
      idle();
      set_a(1'b1, 1'b0, 4'h0, 8'h20, 32'h0); cyc();
      check("rdw_after", rd_a[0], 32'h12345678);

      // Overlapping collision: A owns lanes 0-1, B gets lane 2.
      set_a(1'b1, 1'b1, 4'hF, 8'h30, 32'h0); cyc();
      set_a(1'b1, 1'b1, 4'b0011, 8'h30, 32'hFFFFFFFF);
      set_b(1'b1, 1'b1, 4'b0110, 8'h30, 32'h00000000); cyc();
      check("coll_pulse",  32'(cl[0]), 32'h1);
      check("coll_cnt",    32'(cnt0), 32'h1);
      check("coll_cnt_u1", 32'(cnt1), 32'h1);
      idle();
      set_a(1'b1, 1'b0, 4'h0, 8'h30, 32'h0); cyc();
      check("coll_word",  rd_a[0], 32'h0000FFFF);
      check("coll_clear", 32'(cl[0]), 32'h0);

      // Disjoint masks: both writes land, no collision.
      set_a(1'b1, 1'b1, 4'b0011, 8'h30, 32'hFFFFFFFF);
      set_b(1'b1, 1'b1, 4'b1100, 8'h30, 32'h12345678); cyc();
      check("disj_no_pulse", 32'(cl[0]), 32'h0);
      check("disj_cnt",      32'(cnt0), 32'h1);
      idle();
      set_a(1'b1, 1'b0, 4'h0, 8'h30, 32'h0); cyc();
      check("disj_word", rd_a[0], 32'h1234FFFF);

      // Four more overlapping collisions: 2-bit counter saturates at 3.
      for (int k = 0; k < 4; k++) begin
         set_a(1'b1, 1'b1, 4'hF, 8'h40, 32'h11111111);
         set_b(1'b1, 1'b1, 4'h1, 8'h40, 32'h22222222); cyc();
         if (cl[1]) pulses++;
         idle(); cyc();
      end
      check("sat_pulses", 32'(pulses), 32'd4);
      check("sat_cnt_u1", 32'(cnt1), 32'd3);
      check("sat_cnt_u0", 32'(cnt0), 32'd5);

      // Preload data = address, then stream reads through the output register.
      idle();
      for (int k = 0; k < 8; k++) begin
         set_a(1'b1, 1'b1, 4'hF, 8'(k), 32'(k)); cyc();
      end
      idle();
      for (int k = 0; k < 12; k++) begin
         if (k < 8) set_b(1'b1, 1'b0, 4'h0, 8'(k), 32'h0);
         else       set_b(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
         cyc();
         if (k >= 1 && k <= 8) begin
            check("stream_rvalid", 32'(rv_b[2]), 32'h1);
            check("stream_rdata",  rd_b[2], 32'(k - 1));
         end else begin
            check("stream_idle", 32'(rv_b[2]), 32'h0);
         end
      end

      // Reset during an in-flight read; memory survives.
      set_b(1'b1, 1'b0, 4'h0, 8'h10, 32'h0); cyc();
      idle();
      rst_n = 1'b0;
      #1;
      check("rst_mid_rvalid_b2", 32'(rv_b[2]), 32'h0);
      check("rst_mid_rdata_b2",  rd_b[2], 32'h0);
      check("rst_mid_rvalid_b0", 32'(rv_b[0]), 32'h0);
      check("rst_mid_cnt",       32'(cnt0), 32'h0);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();
      check("rst_post_rvalid", 32'(rv_b[2]), 32'h0);
      set_b(1'b1, 1'b0, 4'h0, 8'h10, 32'h0); cyc();
      check("rst_keep_rdata_b0",  rd_b[0], 32'hAA22CC44);
      check("rst_keep_rvalid_b0", 32'(rv_b[0]), 32'h1);
      check("rst_keep_early_b2",  32'(rv_b[2]), 32'h0);
      idle(); cyc();
      check("rst_keep_rdata_b2",  rd_b[2], 32'hAA22CC44);
      check("rst_keep_rvalid_b2", 32'(rv_b[2]), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
